// File: rtl/pe_net_seq_ctrl.sv
// Sequencer for the PE_net systolic array: weight load, control-word config, frame streaming.
// Optional PE_NET_SEQ_KEEPW_EN adds keep_w_i, letting a start skip the weight load.
module pe_net_seq_ctrl #(
  parameter int unsigned ROW_SIZE = 8,
  parameter int unsigned N        = 4,
  parameter int unsigned M        = 4,
  parameter int unsigned CL_IN    = 4,
  parameter int unsigned CL1      = 2,
  parameter int unsigned LINES    = 16,
  parameter int unsigned W_CYC    = 9,
  parameter int unsigned AW       = 4,
  parameter int unsigned TMO      = 255
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      start_i,
  input  logic                      abort_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      err_o,
  output logic                      cfg_rd_o,
  output logic [AW-1:0]             cfg_addr_o,
  input  logic [ROW_SIZE*M-1:0]     cfg_rdata_i,
  input  logic [ROW_SIZE*CL_IN-1:0] ctl_ch_i,
  input  logic [ROW_SIZE*CL_IN-1:0] ctl_bp_ch_i,
  input  logic [ROW_SIZE*CL1-1:0]   ctl_bp_src_i,
  input  logic                      src_valid_i,
  output logic                      src_ready_o,
  input  logic [ROW_SIZE*N-1:0]     src_data_i,
  output logic [ROW_SIZE*N-1:0]     net_d_in_o,
  output logic [ROW_SIZE-1:0]       net_en_in_o,
  output logic [ROW_SIZE*M-1:0]     net_w_in_o,
  output logic                      net_w_conf_o,
  output logic                      net_cntl_conf_o,
  output logic [ROW_SIZE*CL_IN-1:0] net_d_ch_o,
  output logic [ROW_SIZE*CL_IN-1:0] net_bp_ch_o,
  output logic [ROW_SIZE*CL1-1:0]   net_bp_src_o,
`ifdef PE_NET_SEQ_KEEPW_EN
  input  logic                      keep_w_i,
`endif
  input  logic [ROW_SIZE-1:0]       net_en_out_i
);

  localparam int unsigned Frame = LINES * LINES;
  localparam int unsigned InW   = $clog2(Frame);
  localparam int unsigned OutW  = $clog2(Frame + 1);
  localparam int unsigned WcW   = $clog2(W_CYC + 1);
  localparam int unsigned TmoW  = $clog2(TMO + 1);

  localparam logic [InW-1:0]  InLast  = InW'(Frame - 1);
  localparam logic [OutW-1:0] OutFull = OutW'(Frame);
  localparam logic [WcW-1:0]  WcLast  = WcW'(W_CYC);
  localparam logic [WcW-1:0]  RdLast  = WcW'(W_CYC - 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TMO - 1);

  typedef enum logic [2:0] {StIdle, StWload, StCconf, StStream, StDrain} state_e;

  state_e                    state_q;
  logic                      busy_q, done_q, err_q, cfg_rd_q, src_ready_q;
  logic                      w_conf_q, cntl_conf_q;
  logic [AW-1:0]             cfg_addr_q;
  logic [ROW_SIZE*N-1:0]     d_in_q;
  logic [ROW_SIZE-1:0]       en_in_q;
  logic [ROW_SIZE*M-1:0]     w_in_q;
  logic [ROW_SIZE*CL_IN-1:0] ch_q, bp_ch_q, net_ch_q, net_bp_ch_q;
  logic [ROW_SIZE*CL1-1:0]   bp_src_q, net_bp_src_q;
  logic [InW-1:0]            in_cnt_q;
  logic [OutW-1:0]           out_cnt_q;
  logic [WcW-1:0]            wcnt_q;
  logic [TmoW-1:0]           tmo_q;
  logic                      keep_w;

`ifdef PE_NET_SEQ_KEEPW_EN
  assign keep_w = keep_w_i;
`else
  assign keep_w = 1'b0;
`endif

  // Only lane 0 of the array's enable chain marks a finished output.
  logic unused_en;
  assign unused_en = ^net_en_out_i[ROW_SIZE-1:1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      cfg_rd_q     <= 1'b0;
      cfg_addr_q   <= '0;
      src_ready_q  <= 1'b0;
      w_conf_q     <= 1'b0;
      cntl_conf_q  <= 1'b0;
      d_in_q       <= '0;
      en_in_q      <= '0;
      w_in_q       <= '0;
      ch_q         <= '0;
      bp_ch_q      <= '0;
      bp_src_q     <= '0;
      net_ch_q     <= '0;
      net_bp_ch_q  <= '0;
      net_bp_src_q <= '0;
      in_cnt_q     <= '0;
      out_cnt_q    <= '0;
      wcnt_q       <= '0;
      tmo_q        <= '0;
    end else begin
      done_q      <= 1'b0;
      cfg_rd_q    <= 1'b0;
      w_conf_q    <= 1'b0;
      cntl_conf_q <= 1'b0;
      en_in_q     <= '0;
      if ((state_q == StStream || state_q == StDrain) && net_en_out_i[0] &&
          out_cnt_q != OutFull) begin
        out_cnt_q <= out_cnt_q + OutW'(1);
      end
      if (abort_i) begin
        state_q     <= StIdle;
        busy_q      <= 1'b0;
        src_ready_q <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (start_i) begin
              ch_q      <= ctl_ch_i;
              bp_ch_q   <= ctl_bp_ch_i;
              bp_src_q  <= ctl_bp_src_i;
              err_q     <= 1'b0;
              busy_q    <= 1'b1;
              in_cnt_q  <= '0;
              out_cnt_q <= '0;
              wcnt_q    <= '0;
              tmo_q     <= '0;
              if (keep_w) begin
                state_q <= StCconf;
              end else begin
                state_q    <= StWload;
                cfg_rd_q   <= 1'b1;
                cfg_addr_q <= '0;
              end
            end
          end
          StWload: begin
            if (wcnt_q < RdLast) begin
              cfg_rd_q   <= 1'b1;
              cfg_addr_q <= AW'(wcnt_q + WcW'(1));
            end
            // Read data for address wcnt_q-1 is on cfg_rdata_i this cycle.
            if (wcnt_q != '0) begin
              w_conf_q <= 1'b1;
              w_in_q   <= cfg_rdata_i;
            end
            if (wcnt_q == WcLast) state_q <= StCconf;
            else                  wcnt_q  <= wcnt_q + WcW'(1);
          end
          StCconf: begin
            cntl_conf_q  <= 1'b1;
            net_ch_q     <= ch_q;
            net_bp_ch_q  <= bp_ch_q;
            net_bp_src_q <= bp_src_q;
            src_ready_q  <= 1'b1;
            state_q      <= StStream;
          end
          StStream: begin
            if (src_valid_i && src_ready_q) begin
              d_in_q  <= src_data_i;
              en_in_q <= '1;
              if (in_cnt_q == InLast) begin
                src_ready_q <= 1'b0;
                state_q     <= StDrain;
              end else begin
                in_cnt_q <= in_cnt_q + InW'(1);
              end
            end
          end
          StDrain: begin
            if (out_cnt_q == OutFull) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= StIdle;
            end else if (tmo_q == TmoLast) begin
              err_q   <= 1'b1;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= StIdle;
            end else begin
              tmo_q <= tmo_q + TmoW'(1);
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign err_o           = err_q;
  assign cfg_rd_o        = cfg_rd_q;
  assign cfg_addr_o      = cfg_addr_q;
  assign src_ready_o     = src_ready_q;
  assign net_d_in_o      = d_in_q;
  assign net_en_in_o     = en_in_q;
  assign net_w_in_o      = w_in_q;
  assign net_w_conf_o    = w_conf_q;
  assign net_cntl_conf_o = cntl_conf_q;
  assign net_d_ch_o      = net_ch_q;
  assign net_bp_ch_o     = net_bp_ch_q;
  assign net_bp_src_o    = net_bp_src_q;

endmodule

// File: tb/tb_pe_net_seq_ctrl.sv
// Scoreboard bench for pe_net_seq_ctrl: stimulus pushes expectations, a negedge monitor checks.
module tb_pe_net_seq_ctrl;
  localparam int FRAME = 256;
  localparam int W_CYC = 9;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start = 1'b0, abort = 1'b0, keep_w = 1'b0, echo = 1'b0;
  logic        busy, done, err, cfg_rd, src_ready, w_conf, cntl_conf, src_valid = 1'b0;
  logic [3:0]  cfg_addr;
  logic [31:0] cfg_rdata = '0, ctl_ch = '0, ctl_bp_ch = '0, src_data = '0;
  logic [15:0] ctl_bp_src = '0;
  logic [31:0] d_in, w_in, d_ch, bp_ch;
  logic [15:0] bp_src;
  logic [7:0]  en_in, en_out;

  always #5 clk = ~clk;

  pe_net_seq_ctrl dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort),
    .busy_o(busy), .done_o(done), .err_o(err), .cfg_rd_o(cfg_rd), .cfg_addr_o(cfg_addr),
    .cfg_rdata_i(cfg_rdata), .ctl_ch_i(ctl_ch), .ctl_bp_ch_i(ctl_bp_ch),
    .ctl_bp_src_i(ctl_bp_src), .src_valid_i(src_valid), .src_ready_o(src_ready),
    .src_data_i(src_data), .net_d_in_o(d_in), .net_en_in_o(en_in), .net_w_in_o(w_in),
    .net_w_conf_o(w_conf), .net_cntl_conf_o(cntl_conf), .net_d_ch_o(d_ch),
    .net_bp_ch_o(bp_ch), .net_bp_src_o(bp_src),
`ifdef PE_NET_SEQ_KEEPW_EN
    .keep_w_i(keep_w),
`endif
    .net_en_out_i(en_out)
  );

  function automatic logic [31:0] wword(input logic [3:0] a);
    return 32'h1111_1111 * {28'd0, a};
  endfunction

  function automatic logic [31:0] beat_word(input int i);
    return 32'h0F1E_2D3C + 32'h0103_0507 * i;
  endfunction

  // Weight buffer with one-cycle read latency; array echoes en_in when enabled.
  always @(posedge clk) if (cfg_rd) cfg_rdata <= wword(cfg_addr);
  assign en_out = echo ? en_in : 8'h00;

  logic [31:0] exp_w[$], exp_d[$];
  bit          exp_done[$];
  logic [31:0] exp_ch, exp_bp;
  logic [15:0] exp_src;
  logic [31:0] last_d;
  bit          prev_w;
  int n_chk = 0, n_pass = 0;
  int n_w = 0, n_wrun = 0, n_cc = 0, n_en = 0, n_done = 0, n_rd = 0;
  int cyc = 0, last_en_cyc = 0, done_cyc = 0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      last_d = '0;
      prev_w = 1'b0;
    end else begin
      if (cfg_rd) n_rd++;
      if (w_conf) begin
        n_w++;
        if (!prev_w) n_wrun++;
        if (exp_w.size() == 0) check("w_unexpected", 1, 0);
        else check("w_in", w_in, exp_w.pop_front());
      end
      prev_w = w_conf;
      if (cntl_conf) begin
        n_cc++;
        check("cconf_after_wload", exp_w.size(), 0);
        check("ctl_words", {d_ch, bp_ch, bp_src}, {exp_ch, exp_bp, exp_src});
      end
      if (en_in != 8'h00) begin
        n_en++;
        last_en_cyc = cyc;
        check("en_in_all", en_in, 8'hFF);
        if (exp_d.size() == 0) check("d_unexpected", 1, 0);
        else begin
          last_d = exp_d.pop_front();
          check("d_in", d_in, last_d);
        end
      end else if (busy) begin
        check("d_hold", d_in, last_d);
      end
      if (done) begin
        n_done++;
        done_cyc = cyc;
        if (exp_done.size() == 0) check("done_unexpected", 1, 0);
        else check("err_at_done", err, exp_done.pop_front());
      end
    end
  end

  // vmode 0: valid always; 1: valid pattern 1,0,0. abort_at < 0 means no abort.
  task automatic run_frame(input int vmode, input bit echo_en, input bit exp_err,
                           input int abort_at, input bit stray, input bit kw, input int seed);
    int w0, wr0, cc0, en0, dn0, rd0, acc, t, w;
    echo    = echo_en;
    exp_ch  = 32'h7654_3210 ^ (32'h1111_1111 * seed);
    exp_bp  = 32'hFEDC_BA98 - seed;
    exp_src = 16'hA5C3 ^ 16'(seed);
    ctl_ch = exp_ch; ctl_bp_ch = exp_bp; ctl_bp_src = exp_src;
    if (!kw) for (int k = 0; k < W_CYC; k++) exp_w.push_back(wword(4'(k)));
    if (abort_at < 0) exp_done.push_back(exp_err);
    w0 = n_w; wr0 = n_wrun; cc0 = n_cc; en0 = n_en; dn0 = n_done; rd0 = n_rd;
    @(negedge clk);
    start = 1'b1; keep_w = kw;
    @(negedge clk);
    start = 1'b0; keep_w = 1'b0;
    // Latched words must not follow the inputs after start.
    ctl_ch = ~exp_ch; ctl_bp_ch = ~exp_bp; ctl_bp_src = ~exp_src;
    check("busy_after_start", busy, 1);
    check("err_cleared_on_start", err, 0);
    if (kw) begin
      @(negedge clk);
      check("keepw_cconf", cntl_conf, 1);
    end
    acc = 0; t = 0;
    while (acc < FRAME && t < 4000) begin
      src_valid = (vmode == 0) || (t % 3 == 0);
      src_data  = beat_word(acc + 1000 * seed);
      start     = stray && (acc == 50);
      if (abort_at == acc) begin
        src_valid = 1'b0; start = 1'b0; abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_idle", {busy, src_ready, w_conf, cntl_conf, en_in}, 0);
        repeat (20) @(negedge clk);
        check("abort_no_done", n_done - dn0, 0);
        check("abort_beats", n_en - en0, abort_at);
        check("abort_exp_d_empty", exp_d.size(), 0);
        return;
      end
      if (src_valid && src_ready) begin
        exp_d.push_back(src_data);
        acc++;
      end
      @(negedge clk);
      t++;
    end
    src_valid = 1'b0; start = 1'b0;
    check("stream_complete", acc, FRAME);
    w = 0;
    while (n_done == dn0 && w < 600) begin
      @(negedge clk);
      w++;
    end
    repeat (3) @(negedge clk);
    check("done_count", n_done - dn0, 1);
    check("en_count", n_en - en0, FRAME);
    check("wconf_count", n_w - w0, kw ? 0 : W_CYC);
    check("wconf_runs", n_wrun - wr0, kw ? 0 : 1);
    check("rd_count", n_rd - rd0, kw ? 0 : W_CYC);
    check("cconf_count", n_cc - cc0, 1);
    check("queues_empty", {exp_w.size(), exp_d.size(), exp_done.size()}, 0);
    check("idle_after_done", busy, 0);
  endtask

  initial begin
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ctrl", {busy, done, err, cfg_rd, cfg_addr, src_ready, w_conf, cntl_conf, en_in}, 0);
    check("rst_data", {d_in, w_in}, 0);
    check("rst_ctl", {d_ch, bp_ch, bp_src}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // T1 full frame
    run_frame(0, 1'b1, 1'b0, -1, 1'b0, 1'b0, 1);
    check("t1_done_latency", done_cyc - last_en_cyc, 2);
    check("t1_err", err, 0);

    // T2 backpressure with a stray start mid-stream
    run_frame(1, 1'b1, 1'b0, -1, 1'b1, 1'b0, 2);

    // T3 drain timeout
    run_frame(0, 1'b0, 1'b1, -1, 1'b0, 1'b0, 3);
    check("t3_timeout_len", done_cyc - last_en_cyc, 255);
    check("t3_err_sticky", err, 1);

    // T4 abort at beat 100, then a clean frame
    run_frame(0, 1'b1, 1'b0, 100, 1'b0, 1'b0, 4);
    run_frame(0, 1'b1, 1'b0, -1, 1'b0, 1'b0, 5);

    // T5 reset mid-WLOAD, then a frame that must reread from address 0
    for (int k = 0; k < W_CYC; k++) exp_w.push_back(wword(4'(k)));
    exp_done.push_back(1'b0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_ctrl", {busy, done, err, cfg_rd, cfg_addr, src_ready, w_conf, cntl_conf, en_in}, 0);
    check("t5_rst_data", {d_in, w_in}, 0);
    exp_w.delete();
    exp_done.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_frame(0, 1'b1, 1'b0, -1, 1'b0, 1'b0, 6);

`ifdef PE_NET_SEQ_KEEPW_EN
    // T6 keep_w start skips the weight load
    run_frame(0, 1'b1, 1'b0, -1, 1'b0, 1'b1, 7);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
